// File: rtl/seq_detect_pkg.sv
// Shared defaults, FSM encoding and reset constants for the sequence detector.
package seq_detect_pkg;

  localparam int unsigned PAT_W_DEF  = 12;
  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned CNT_W_DEF  = 16;

  // Pattern loaded by reset; overlapping detection is the reset mode.
  localparam logic [11:0] RESET_PATTERN = 12'hEDB;
  localparam logic        RESET_OVERLAP = 1'b1;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/seq_window.sv
// Sliding bit window with saturating fill counter and pattern comparator.
module seq_window #(
  parameter int unsigned PAT_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             shift_en,
  input  logic             bit_in,
  input  logic             clr_fill,
  input  logic [PAT_W-1:0] pattern,
  output logic             hit
);

  localparam int unsigned FILL_W = $clog2(PAT_W + 1);

  logic [PAT_W-1:0]  window;
  logic [FILL_W-1:0] fill;
  logic [PAT_W-1:0]  next_window;
  logic [FILL_W-1:0] next_fill;

  // Window/fill after shifting bit_in; hit flags a full window equal to the pattern.
  always_comb begin
    next_window = {window[PAT_W-2:0], bit_in};
    next_fill   = (fill == FILL_W'(PAT_W)) ? fill : fill + FILL_W'(1);
    hit         = shift_en && (next_window == pattern) && (next_fill == FILL_W'(PAT_W));
  end

  // Window state: cleared by configuration, advanced one bit per shift.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      window <= '0;
      fill   <= '0;
    end else if (clr) begin
      window <= '0;
      fill   <= '0;
    end else if (shift_en) begin
      window <= next_window;
      fill   <= (hit && clr_fill) ? '0 : next_fill;
    end
  end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Byte-fed serial pattern detector with match pulse and saturating match counter.
module seq_detect_ctrl
  import seq_detect_pkg::*;
#(
  parameter int unsigned PAT_W  = PAT_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [PAT_W-1:0]  cfg_pattern,
  input  logic              cfg_overlap,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              match,
  output logic [CNT_W-1:0]  match_count,
  output logic              busy
);

  localparam int unsigned IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  state_t            state;
  logic [DATA_W-1:0] byte_q;
  logic [IDX_W-1:0]  bit_idx;
  logic [PAT_W-1:0]  pattern;
  logic              overlap;
  logic              last_bit;
  logic              cfg_load;
  logic              shift_en;
  logic              hit;

  // Handshake and window control decoded from the current state.
  always_comb begin
    last_bit = (bit_idx == IDX_W'(DATA_W - 1));
    shift_en = (state == SHIFT);
    cfg_load = (state == IDLE) && cfg_we;
    in_ready = ((state == IDLE) && !cfg_we) || ((state == SHIFT) && last_bit);
    busy     = (state == SHIFT);
  end

  seq_window #(
    .PAT_W (PAT_W)
  ) u_window (
    .clk      (clk),
    .rst      (rst),
    .clr      (cfg_load),
    .shift_en (shift_en),
    .bit_in   (byte_q[DATA_W-1]),
    .clr_fill (!overlap),
    .pattern  (pattern),
    .hit      (hit)
  );

  // Controller FSM: configuration and byte intake in IDLE, MSB-first serialisation in SHIFT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      byte_q      <= '0;
      bit_idx     <= '0;
      pattern     <= PAT_W'(RESET_PATTERN);
      overlap     <= RESET_OVERLAP;
      match       <= 1'b0;
      match_count <= '0;
    end else begin
      match <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg_we) begin
            pattern     <= cfg_pattern;
            overlap     <= cfg_overlap;
            match_count <= '0;
          end else if (in_valid) begin
            byte_q  <= in_data;
            bit_idx <= '0;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          byte_q  <= byte_q << 1;
          bit_idx <= bit_idx + IDX_W'(1);
          if (hit) begin
            match <= 1'b1;
            if (match_count != '1) begin
              match_count <= match_count + CNT_W'(1);
            end
          end
          if (last_bit) begin
            bit_idx <= '0;
            if (in_valid) begin
              byte_q <= in_data;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Randomised bench for seq_detect_ctrl against a bit-queue reference model.
module tb_seq_detect_ctrl;

  localparam int unsigned PAT_W   = 12;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned CNT_S_W = 3;
  localparam int          CNT_MAX   = 65535;
  localparam int          CNT_S_MAX = 7;
  localparam int          WIN_MASK  = 4095;

  logic              clk;
  logic              rst;
  logic              cfg_we;
  logic [PAT_W-1:0]  cfg_pattern;
  logic              cfg_overlap;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready, match, busy;
  logic [CNT_W-1:0]  match_count;
  logic              in_ready_s, match_s, busy_s;
  logic [CNT_S_W-1:0] match_count_s;

  seq_detect_ctrl #(.PAT_W(PAT_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
    .cfg_overlap(cfg_overlap), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .match(match), .match_count(match_count), .busy(busy)
  );

  // Narrow-counter copy sharing the same stimulus, used to reach saturation quickly.
  seq_detect_ctrl #(.PAT_W(PAT_W), .DATA_W(DATA_W), .CNT_W(CNT_S_W)) dut_s (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
    .cfg_overlap(cfg_overlap), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_data(in_data), .match(match_s), .match_count(match_count_s), .busy(busy_s)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: bits still to be shifted, window contents and config.
  bit q[$];
  int win, fill, pat, exp_cnt, exp_cnt_s;
  bit ovl, exp_match;

  // Observation counters for directed windows.
  int pulses, busy_cycles, ready_busy;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    q.delete();
    win = 0; fill = 0; pat = 'hEDB; ovl = 1'b1;
    exp_match = 1'b0; exp_cnt = 0; exp_cnt_s = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0; cfg_we = 1'b0; rst = 1'b1;
    #1;
    check("rst_match", 32'(match), 32'd0);
    check("rst_count", 32'(match_count), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_count_s", 32'(match_count_s), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One clock: drive, check outputs of the previous edge, then advance the model.
  task automatic do_cycle(input bit v, input logic [7:0] d, input bit we,
                          input logic [11:0] cp, input bit co);
    bit exp_ready, acc, b;
    @(negedge clk);
    in_valid = v; in_data = d; cfg_we = we; cfg_pattern = cp; cfg_overlap = co;
    #1;
    exp_ready = (q.size() == 0 && !we) || (q.size() == 1);
    check("in_ready", 32'(in_ready), 32'(exp_ready));
    check("busy", 32'(busy), 32'(q.size() != 0));
    check("match", 32'(match), 32'(exp_match));
    check("match_count", 32'(match_count), 32'(exp_cnt));
    check("match_count_s", 32'(match_count_s), 32'(exp_cnt_s));
    if (match) pulses++;
    if (busy) busy_cycles++;
    if (busy && in_ready) ready_busy++;
    acc = v && exp_ready;
    exp_match = 1'b0;
    if (q.size() != 0) begin
      b = q.pop_front();
      win = ((win << 1) | int'(b)) & WIN_MASK;
      if (fill < 12) fill++;
      if (win == pat && fill == 12) begin
        exp_match = 1'b1;
        if (exp_cnt < CNT_MAX) exp_cnt++;
        if (exp_cnt_s < CNT_S_MAX) exp_cnt_s++;
        if (!ovl) fill = 0;
      end
    end else if (we) begin
      pat = int'(cp); ovl = co; win = 0; fill = 0; exp_cnt = 0; exp_cnt_s = 0;
    end
    if (acc) for (int i = 7; i >= 0; i--) q.push_back(d[i]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) do_cycle(1'b0, 8'h00, 1'b0, 12'h000, 1'b0);
  endtask

  task automatic configure(input logic [11:0] p, input bit o);
    do_cycle(1'b0, 8'h00, 1'b1, p, o);
  endtask

  // Two bytes back to back: second byte offered exactly at the last bit of the first.
  task automatic send2(input logic [7:0] a, input logic [7:0] b);
    do_cycle(1'b1, a, 1'b0, 12'h000, 1'b0);
    idle(7);
    do_cycle(1'b1, b, 1'b0, 12'h000, 1'b0);
    idle(10);
  endtask

  function automatic logic [7:0] pick_byte();
    case ($urandom_range(0, 4))
      0: return 8'hED;
      1: return 8'hB0;
      2: return 8'hFF;
      3: return 8'hDB;
      default: return 8'($urandom);
    endcase
  endfunction

  function automatic logic [11:0] pick_pat();
    case ($urandom_range(0, 3))
      0: return 12'hEDB;
      1: return 12'hFFF;
      2: return 12'hB6D;
      default: return 12'($urandom);
    endcase
  endfunction

  initial begin
    clk = 1'b0; rst = 1'b1; cfg_we = 1'b0; cfg_pattern = '0; cfg_overlap = 1'b0;
    in_valid = 1'b0; in_data = '0;
    model_reset();
    do_reset();

    // Default pattern EDB, overlapping: single match.
    pulses = 0;
    idle(2);
    send2(8'hED, 8'hB0);
    check("edb_pulses", 32'(pulses), 32'd1);
    check("edb_count", 32'(match_count), 32'd1);

    // All-ones pattern, overlapping then non-overlapping.
    configure(12'hFFF, 1'b1);
    pulses = 0;
    send2(8'hFF, 8'hFF);
    check("fff_ov_pulses", 32'(pulses), 32'd5);
    check("fff_ov_count", 32'(match_count), 32'd5);
    configure(12'hFFF, 1'b0);
    send2(8'hFF, 8'hFF);
    check("fff_nov_count", 32'(match_count), 32'd1);

    // Continuous in_valid for three bytes; narrow counter saturates.
    configure(12'hFFF, 1'b1);
    busy_cycles = 0; ready_busy = 0;
    for (int i = 0; i < 24; i++) do_cycle(1'b1, 8'hFF, 1'b0, 12'h000, 1'b0);
    idle(10);
    check("stream_busy", 32'(busy_cycles), 32'd24);
    check("stream_ready", 32'(ready_busy), 32'd3);
    check("stream_count", 32'(match_count), 32'd13);
    check("sat_count_s", 32'(match_count_s), 32'd7);

    // cfg_we during SHIFT is ignored; cfg_we with in_valid in IDLE wins.
    configure(12'hEDB, 1'b1);
    send2(8'hED, 8'hB0);
    do_cycle(1'b1, 8'hED, 1'b0, 12'h000, 1'b0);
    do_cycle(1'b0, 8'h00, 1'b1, 12'h000, 1'b0);
    idle(6);
    do_cycle(1'b1, 8'hB0, 1'b1, 12'h000, 1'b0);
    idle(10);
    check("shift_cfg_count", 32'(match_count), 32'd2);
    do_cycle(1'b1, 8'hED, 1'b1, 12'hEDB, 1'b1);
    check("cfg_prio_ready", 32'(in_ready), 32'd0);
    idle(2);

    // Reset four bits into a byte, then a clean detection.
    do_cycle(1'b1, 8'hED, 1'b0, 12'h000, 1'b0);
    idle(4);
    do_reset();
    send2(8'hED, 8'hB0);
    check("post_rst_count", 32'(match_count), 32'd1);

    // Random traffic, configuration and resets.
    for (int i = 0; i < 4000; i++) begin
      int r;
      r = int'($urandom_range(0, 199));
      if (r < 2) do_reset();
      else if (r < 10) do_cycle($urandom_range(0, 1) == 1, pick_byte(), 1'b1, pick_pat(),
                                $urandom_range(0, 1) == 1);
      else do_cycle($urandom_range(0, 99) < 75, pick_byte(), 1'b0, pick_pat(), 1'b0);
    end
    idle(12);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
